sid_filter_mc: RTL and testbench

//  Multi-voice SID filter engine. Accepts NUM_VOICES unsigned voice samples per frame
//  and routes each voice either through a time-multiplexed Chamberlin SVF or around it.

---
 rtl/sid_filter_pkg.sv | 34 +++
 rtl/sid_filter_mc_shift_mul.sv | 32 +++
 rtl/sid_filter_mc.sv | 194 +++++++++++++++++++
 tb/tb_sid_filter_mc.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sid_filter_pkg.sv
// rtl/sid_filter_pkg.sv - shared types, constants and saturation helper for the SID filter engine
// Contents: state_t FSM enum, GUARD_W_DEF default headroom, ALPHA2_BASE damping constant, sat().
package sid_filter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUM,
        S_HP,
        S_BP,
        S_LP,
        S_MIX
    } state_t;

    localparam int GUARD_W_DEF = 2;

    // alpha2 = ALPHA2_BASE - res, so res=15 gives the least damping.
    localparam int ALPHA2_BASE = 15;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            sat = hi;
        end else if (x < lo) begin
            sat = lo;
        end else begin
            sat = x;
        end
    endfunction

endpackage

// File: rtl/sid_filter_mc_shift_mul.sv
// rtl/sid_filter_mc_shift_mul.sv - combinational signed x unsigned shift-add product, arithmetic right shift
// Ports: a (in, ACC_W signed operand), k (in, K-bit unsigned coefficient),
//        p (out, ACC_W+K signed, (a*k) >>> SHIFT).
module svf_shift_mul #(
    parameter int ACC_W = 12,
    parameter int K     = 7,
    parameter int SHIFT = 7
) (
    input  logic signed [ACC_W-1:0]   a,
    input  logic        [K-1:0]       k,
    output logic signed [ACC_W+K-1:0] p
);

    localparam int PW = ACC_W + K;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] acc;

    assign a_ext = {{K{a[ACC_W-1]}}, a};

    // Product of an ACC_W signed and a K-bit unsigned value always fits in PW bits.
    always_comb begin
        acc = '0;
        for (int i = 0; i < K; i++) begin
            if (k[i]) begin
                acc = acc + (a_ext <<< i);
            end
        end
        p = acc >>> SHIFT;
    end

endmodule

// File: rtl/sid_filter_mc.sv
// rtl/sid_filter_mc.sv - multi-voice SID filter: time-multiplexed Chamberlin SVF, mode mix, master volume
// Optional feature macro: SID_FILTER_OVERRUN_EN (adds ovr_clr / overrun sticky drop flag).
// Ports: clk, rst_n (async, active low); voice_in (NUM_VOICES x DATA_W unsigned);
//        sample_valid (frame strobe); fc (cutoff, alpha1=fc[10:4]); res (alpha2=15-res);
//        filt (per-voice SVF routing); mode (LP/BP/HP enables); vol (master volume);
//        sample_out (registered mix); out_valid (one-cycle pulse); busy (not IDLE);
//        [ovr_clr (in), overrun (out)] with SID_FILTER_OVERRUN_EN.
module sid_filter_mc
    import sid_filter_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int DATA_W     = 8,
    parameter int GUARD_W    = GUARD_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_VOICES*DATA_W-1:0] voice_in,
    input  logic                         sample_valid,
    input  logic [10:0]                  fc,
    input  logic [3:0]                   res,
    input  logic [NUM_VOICES-1:0]        filt,
    input  logic [2:0]                   mode,
    input  logic [3:0]                   vol,
`ifdef SID_FILTER_OVERRUN_EN
    input  logic                         ovr_clr,
    output logic                         overrun,
`endif
    output logic [DATA_W-1:0]            sample_out,
    output logic                         out_valid,
    output logic                         busy
);

    localparam int ACC_W = DATA_W + $clog2(NUM_VOICES) + GUARD_W;
    localparam int VC_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VC_W-1:0] LAST_V = VC_W'(NUM_VOICES - 1);

    state_t state_q, state_d;

    logic [VC_W-1:0]              vcnt;
    logic [NUM_VOICES*DATA_W-1:0] voice_q;
    logic [6:0]                   a1_q;
    logic [3:0]                   a2_q;
    logic [NUM_VOICES-1:0]        filt_q;
    logic [2:0]                   mode_q;
    logic [3:0]                   vol_q;
    logic signed [ACC_W-1:0]      f_acc, d_acc, hp_q, bp_q, lp_q;

    logic [DATA_W-1:0]            cur_voice;
    logic signed [ACC_W-1:0]      s_ext;
    logic signed [ACC_W-1:0]      mul_a1_in;
    logic signed [ACC_W+6:0]      p1;
    logic signed [ACC_W+3:0]      p2;
    logic signed [ACC_W-1:0]      hp_next, bp_next, lp_next;
    logic signed [31:0]           mix;
    logic signed [DATA_W-1:0]     y;
    logic [DATA_W-1:0]            u;
    logic [DATA_W-1:0]            scaled;
    logic                         bypass;

    assign busy   = (state_q != S_IDLE);
    assign bypass = (filt_q == '0) || (mode_q == 3'b000);

    // Offset-binary to two's complement is an MSB flip, then sign-extend.
    assign cur_voice = voice_q[vcnt*DATA_W +: DATA_W];
    assign s_ext     = {{(ACC_W-DATA_W){~cur_voice[DATA_W-1]}}, ~cur_voice[DATA_W-1], cur_voice[DATA_W-2:0]};

    // One alpha1 multiplier serves both integrators: hp in BP state, updated bp in LP state.
    assign mul_a1_in = (state_q == S_LP) ? bp_q : hp_q;

    svf_shift_mul #(.ACC_W(ACC_W), .K(7), .SHIFT(7)) u_mul_a1 (
        .a (mul_a1_in),
        .k (a1_q),
        .p (p1)
    );

    svf_shift_mul #(.ACC_W(ACC_W), .K(4), .SHIFT(3)) u_mul_a2 (
        .a (bp_q),
        .k (a2_q),
        .p (p2)
    );

    always_comb begin
        hp_next = ACC_W'(sat(32'(f_acc) - 32'(lp_q) - 32'(p2), ACC_W));
        bp_next = ACC_W'(sat(32'(bp_q) + 32'(p1), ACC_W));
        lp_next = ACC_W'(sat(32'(lp_q) + 32'(p1), ACC_W));

        mix = '0;
        if (bypass) begin
            mix = 32'(f_acc);
        end else begin
            if (mode_q[0]) mix = mix + 32'(lp_q);
            if (mode_q[1]) mix = mix + 32'(bp_q);
            if (mode_q[2]) mix = mix + 32'(hp_q);
        end

        y = DATA_W'(sat(mix + 32'(d_acc), DATA_W));
        u = {~y[DATA_W-1], y[DATA_W-2:0]};

        // vol[3] weights u/2 down to vol[0] weighting u/16.
        scaled = '0;
        for (int i = 1; i <= 4; i++) begin
            if (vol_q[4-i]) begin
                scaled = scaled + (u >> i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (sample_valid) state_d = S_SUM;
            S_SUM:   if (vcnt == LAST_V) state_d = S_HP;
            S_HP:    state_d = S_BP;
            S_BP:    state_d = S_LP;
            S_LP:    state_d = S_MIX;
            S_MIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcnt       <= '0;
            voice_q    <= '0;
            a1_q       <= '0;
            a2_q       <= '0;
            filt_q     <= '0;
            mode_q     <= '0;
            vol_q      <= '0;
            f_acc      <= '0;
            d_acc      <= '0;
            hp_q       <= '0;
            bp_q       <= '0;
            lp_q       <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        voice_q <= voice_in;
                        a1_q    <= 7'(fc >> 4);
                        a2_q    <= 4'(ALPHA2_BASE) - res;
                        filt_q  <= filt;
                        mode_q  <= mode;
                        vol_q   <= vol;
                        vcnt    <= '0;
                        f_acc   <= '0;
                        d_acc   <= '0;
                    end
                end
                S_SUM: begin
                    if (filt_q[vcnt]) begin
                        f_acc <= f_acc + s_ext;
                    end else begin
                        d_acc <= d_acc + s_ext;
                    end
                    vcnt <= vcnt + VC_W'(1);
                end
                S_HP:  if (!bypass) hp_q <= hp_next;
                S_BP:  if (!bypass) bp_q <= bp_next;
                S_LP:  if (!bypass) lp_q <= lp_next;
                S_MIX: begin
                    sample_out <= scaled;
                    out_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SID_FILTER_OVERRUN_EN
    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (sample_valid && (state_q != S_IDLE)) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sid_filter_mc.sv
// tb/tb_sid_filter_mc.sv - self-checking bench for sid_filter_mc against an integer reference model
module tb_sid_filter_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] voice_in = '0;
    logic        sample_valid = 1'b0;
    logic [10:0] fc = '0;
    logic [3:0]  res = '0;
    logic [2:0]  filt = '0;
    logic [2:0]  mode = '0;
    logic [3:0]  vol = '0;
    logic [7:0]  sample_out;
    logic        out_valid;
    logic        busy;
`ifdef SID_FILTER_OVERRUN_EN
    logic        ovr_clr = 1'b0;
    logic        overrun;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int m_lp     = 0;
    int m_bp     = 0;

    sid_filter_mc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .voice_in     (voice_in),
        .sample_valid (sample_valid),
        .fc           (fc),
        .res          (res),
        .filt         (filt),
        .mode         (mode),
        .vol          (vol),
`ifdef SID_FILTER_OVERRUN_EN
        .ovr_clr      (ovr_clr),
        .overrun      (overrun),
`endif
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampw(input int x, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (x > hi) ? hi : ((x < lo) ? lo : x);
    endfunction

    function automatic int floor_div(input int a, input int d);
        int q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Frame-level model: sums, one SVF step on persistent lp/bp, mix, volume.
    function automatic int model_frame(input logic [23:0] v, input logic [10:0] f,
                                       input logic [3:0] r, input logic [2:0] fl,
                                       input logic [2:0] md, input logic [3:0] vl);
        int fa, da, s, a1, a2, hp, m, yv, uv;
        fa = 0;
        da = 0;
        for (int i = 0; i < 3; i++) begin
            s = int'(v[i*8 +: 8]) - 128;
            if (fl[i]) fa += s; else da += s;
        end
        a1 = int'(f >> 4);
        a2 = 15 - int'(r);
        if (fl == 0 || md == 0) begin
            m = fa;
        end else begin
            hp   = clampw(fa - m_lp - floor_div(m_bp * a2, 8), 12);
            m_bp = clampw(m_bp + floor_div(hp * a1, 128), 12);
            m_lp = clampw(m_lp + floor_div(m_bp * a1, 128), 12);
            m = (md[0] ? m_lp : 0) + (md[1] ? m_bp : 0) + (md[2] ? hp : 0);
        end
        yv = clampw(m + da, 8);
        uv = yv + 128;
        return (vl[3] ? uv / 2 : 0) + (vl[2] ? uv / 4 : 0) + (vl[1] ? uv / 8 : 0) + (vl[0] ? uv / 16 : 0);
    endfunction

    // Starts just after a clock edge. drop_at>0 pulses sample_valid so edge drop_at samples it.
    task automatic run_frame(input string tag, input logic [23:0] v, input logic [10:0] f,
                             input logic [3:0] r, input logic [2:0] fl, input logic [2:0] md,
                             input logic [3:0] vl, input int drop_at, output int outv);
        int exp, cnt, lat, pulses;
        bit done;
        exp = model_frame(v, f, r, fl, md, vl);
        voice_in = v; fc = f; res = r; filt = fl; mode = md; vol = vl;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk({tag, "_busy"}, int'(busy), 1);
        voice_in = 24'($urandom); fc = 11'($urandom); res = 4'($urandom);
        filt = 3'($urandom); mode = 3'($urandom); vol = 4'($urandom);
        cnt = 0; lat = -1; pulses = 0; outv = -1; done = 0;
        while (cnt < 20 && !done) begin
            @(posedge clk); #1;
            cnt++;
            sample_valid = (drop_at > 0 && cnt == drop_at - 1);
            if (out_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = cnt;
                    outv = int'(sample_out);
                end
            end
            if (drop_at == 0 && lat >= 0) done = 1;
            if (drop_at > 0 && cnt >= 14) done = 1;
        end
        sample_valid = 1'b0;
        chk({tag, "_lat"}, lat, 7);
        chk({tag, "_out"}, outv, exp);
        if (drop_at > 0) chk({tag, "_pulses"}, pulses, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int o, prev, pulses;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", int'(sample_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
`ifdef SID_FILTER_OVERRUN_EN
        chk("rst_ovr", int'(overrun), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame("byp90", 24'h909090, 11'h7F0, 4'd0, 3'b000, 3'b001, 4'hF, 0, o);
        chk("byp90_const", o, 165);
        run_frame("vol0", 24'h8080FF, 11'h000, 4'd0, 3'b000, 3'b000, 4'h0, 0, o);
        chk("vol0_const", o, 0);
        run_frame("vol8", 24'h8080FF, 11'h000, 4'd0, 3'b000, 3'b000, 4'h8, 0, o);
        chk("vol8_const", o, 127);
        run_frame("satp", 24'hFFFFFF, 11'h000, 4'd0, 3'b000, 3'b111, 4'hF, 0, o);
        chk("satp_noneg", int'(o >= 128), 1);
        run_frame("satn", 24'h000000, 11'h000, 4'd0, 3'b000, 3'b111, 4'hF, 0, o);

        for (int i = 0; i < 12; i++) begin
            run_frame("lpstep", 24'h8080C0, 11'h7F0, 4'd0, 3'b001, 3'b001, 4'hF, 0, o);
        end
        for (int i = 0; i < 8; i++) begin
            run_frame("bpmix", 24'hA06040, 11'h200, 4'd12, 3'b011, 3'b110, 4'hC, 0, o);
        end

        run_frame("drop2", 24'h7088F0, 11'h300, 4'd5, 3'b101, 3'b011, 4'hF, 2, o);
`ifdef SID_FILTER_OVERRUN_EN
        chk("ovr_set", int'(overrun), 1);
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        chk("ovr_clr", int'(overrun), 0);
`endif
        run_frame("dropmix", 24'h11EE80, 11'h150, 4'd9, 3'b010, 3'b100, 4'h7, 7, o);

        // Reset two cycles into SUM aborts the frame and clears filter state.
        voice_in = 24'hFFFFFF; filt = 3'b111; mode = 3'b001; vol = 4'hF;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", int'(sample_out), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        m_lp = 0;
        m_bp = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        chk("mid_rst_nopulse", pulses, 0);
        run_frame("post_rst", 24'h8080C0, 11'h7F0, 4'd3, 3'b001, 3'b001, 4'hF, 0, o);

        prev = -1;
        for (int i = 0; i < 30; i++) begin
            run_frame("rand", 24'($urandom), 11'($urandom), 4'($urandom), 3'($urandom),
                      3'($urandom), 4'($urandom), 0, o);
            prev = o;
        end
        if (prev < 0) chk("rand_seen", prev, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
